// File: rtl/clause_eval_if.sv
// clause_eval_if
// Groups the clause-scan handshake and verdict signals of clause_eval.
//   master : drives start_i and the literal stream, observes status/verdict
//   slave  : the evaluator; accepts the stream, returns status/verdict
//   start_i, lit_valid_i, lit_i[2:0], lit_last_i  -> evaluator
//   lit_ready_o, busy_o, done_o, sat_o, unit_o, conflict_o,
//   imp_idx_o[IDX_W-1:0], freelitcnt_o[1:0]       <- evaluator
interface clause_eval_if #(
    parameter int IDX_W = 3
);
    logic             start_i;
    logic             lit_valid_i;
    logic [2:0]       lit_i;
    logic             lit_last_i;
    logic             lit_ready_o;
    logic             busy_o;
    logic             done_o;
    logic             sat_o;
    logic             unit_o;
    logic             conflict_o;
    logic [IDX_W-1:0] imp_idx_o;
    logic [1:0]       freelitcnt_o;

    modport master (
        output start_i, lit_valid_i, lit_i, lit_last_i,
        input  lit_ready_o, busy_o, done_o, sat_o, unit_o, conflict_o,
               imp_idx_o, freelitcnt_o
    );

    modport slave (
        input  start_i, lit_valid_i, lit_i, lit_last_i,
        output lit_ready_o, busy_o, done_o, sat_o, unit_o, conflict_o,
               imp_idx_o, freelitcnt_o
    );
endinterface

// File: rtl/clause_eval.sv
// clause_eval
// Scans one clause's literal states serially (one literal per beat), keeps
// the free-literal count, and at end of clause registers a verdict:
// satisfied, unit (with the literal index to imply) or conflict.
// Ports:
//   clk  - clock, rising edge
//   rst  - asynchronous active-low reset
//   bus  - clause_eval_if.slave: start/literal stream in, status/verdict out
//
// state  | meaning
// IDLE   | waiting for start_i; last verdict held on the outputs
// SCAN   | accepting literal beats, accumulating sat/conflict/free info
// REPORT | verdict valid for the first cycle, done_o pulsed
module clause_eval #(
    parameter int NUM_LITS = 8,
    parameter int IDX_W    = 3
) (
    input  logic         clk,
    input  logic         rst,
    clause_eval_if.slave bus
);

    typedef enum logic [1:0] {IDLE, SCAN, REPORT} state_t;

    localparam logic [1:0]       V_FREE   = 2'd0;
    localparam logic [1:0]       V_TRUE   = 2'd2;
    localparam logic [1:0]       V_CONFL  = 2'd3;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_LITS - 1);

    state_t           state_q;
    logic [IDX_W-1:0] idx_q;
    logic [1:0]       freecnt_q;
    logic             sat_seen_q;
    logic             confl_seen_q;
    logic [IDX_W-1:0] free_idx_q;

    logic             lit_ready_q;
    logic             busy_q;
    logic             done_q;
    logic             sat_q;
    logic             unit_q;
    logic             conflict_q;
    logic [IDX_W-1:0] imp_idx_q;
    logic [1:0]       freelitcnt_q;

    logic             beat;
    logic             scan_end;
    logic [1:0]       value;
    logic             sat_seen_d;
    logic             confl_seen_d;
    logic [1:0]       freecnt_d;
    logic [IDX_W-1:0] free_idx_d;
    logic             sat_d;
    logic             unit_d;
    logic             conflict_d;

    // The implied flag is not part of the evaluation.
    logic unused_implied;
    assign unused_implied = bus.lit_i[0];

    // Accumulators including the current beat, so the verdict can be
    // registered on the same edge that accepts the final literal.
    always_comb begin
        value        = bus.lit_i[2:1];
        // lit_ready_q is only set in SCAN; a beat alongside start_i is dropped
        beat         = bus.lit_valid_i && lit_ready_q && !bus.start_i;
        scan_end     = beat && (bus.lit_last_i || (idx_q == LAST_IDX));
        sat_seen_d   = sat_seen_q || (beat && (value == V_TRUE));
        confl_seen_d = confl_seen_q || (beat && (value == V_CONFL));
        freecnt_d    = freecnt_q;
        free_idx_d   = free_idx_q;
        if (beat && (value == V_FREE)) begin
            if (freecnt_q == 2'd0) begin
                freecnt_d  = 2'd1;
                free_idx_d = idx_q;
            end else begin
                // saturates at 3: "two or more"
                freecnt_d  = 2'd3;
            end
        end
        sat_d      = sat_seen_d;
        conflict_d = !sat_seen_d && (confl_seen_d || (freecnt_d == 2'd0));
        unit_d     = !sat_seen_d && !confl_seen_d && (freecnt_d == 2'd1);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            idx_q        <= '0;
            freecnt_q    <= 2'd0;
            sat_seen_q   <= 1'b0;
            confl_seen_q <= 1'b0;
            free_idx_q   <= '0;
            lit_ready_q  <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            sat_q        <= 1'b0;
            unit_q       <= 1'b0;
            conflict_q   <= 1'b0;
            imp_idx_q    <= '0;
            freelitcnt_q <= 2'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.start_i) begin
                        state_q      <= SCAN;
                        idx_q        <= '0;
                        freecnt_q    <= 2'd0;
                        sat_seen_q   <= 1'b0;
                        confl_seen_q <= 1'b0;
                        free_idx_q   <= '0;
                        lit_ready_q  <= 1'b1;
                        busy_q       <= 1'b1;
                        sat_q        <= 1'b0;
                        unit_q       <= 1'b0;
                        conflict_q   <= 1'b0;
                        imp_idx_q    <= '0;
                        freelitcnt_q <= 2'd0;
                    end
                end
                SCAN: begin
                    if (bus.start_i) begin
                        // abort: verdict outputs are already clear in SCAN
                        idx_q        <= '0;
                        freecnt_q    <= 2'd0;
                        sat_seen_q   <= 1'b0;
                        confl_seen_q <= 1'b0;
                        free_idx_q   <= '0;
                    end else if (beat) begin
                        sat_seen_q   <= sat_seen_d;
                        confl_seen_q <= confl_seen_d;
                        freecnt_q    <= freecnt_d;
                        free_idx_q   <= free_idx_d;
                        if (scan_end) begin
                            // idx stays put so it never passes NUM_LITS-1
                            state_q      <= REPORT;
                            lit_ready_q  <= 1'b0;
                            done_q       <= 1'b1;
                            sat_q        <= sat_d;
                            unit_q       <= unit_d;
                            conflict_q   <= conflict_d;
                            imp_idx_q    <= unit_d ? free_idx_d : '0;
                            freelitcnt_q <= freecnt_d;
                        end else begin
                            idx_q <= idx_q + IDX_W'(1);
                        end
                    end
                end
                REPORT: begin
                    state_q <= IDLE;
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q     <= IDLE;
                    lit_ready_q <= 1'b0;
                    busy_q      <= 1'b0;
                    done_q      <= 1'b0;
                end
            endcase
        end
    end

    assign bus.lit_ready_o  = lit_ready_q;
    assign bus.busy_o       = busy_q;
    assign bus.done_o       = done_q;
    assign bus.sat_o        = sat_q;
    assign bus.unit_o       = unit_q;
    assign bus.conflict_o   = conflict_q;
    assign bus.imp_idx_o    = imp_idx_q;
    assign bus.freelitcnt_o = freelitcnt_q;

endmodule
